// File: rtl/pwm_frame_driver.sv
// Double-buffered 12-channel PWM driver fed by the 96-bit duty frame from the upstream stage.
// A loaded frame waits in a shadow register and moves to the active duties only at a period wrap (or while idle).

module pwm_lane #(
  parameter int DW = 8
) (
  input  logic          sys_clk,
  input  logic          sys_resetb,
  input  logic          en_i,
  input  logic [DW-1:0] cnt_i,
  input  logic [DW-1:0] duty_i,
  output logic          pwm_o
);
  logic pwm_q;

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) pwm_q <= 1'b0;
    else             pwm_q <= en_i && (cnt_i < duty_i);
  end

  assign pwm_o = pwm_q;
endmodule

module pwm_frame_driver #(
  parameter int NUM_CH     = 12,
  parameter int DW         = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_resetb,
  input  logic                   enable,
  input  logic [PRESCALE_W-1:0]  prescale,
  input  logic                   load,
  input  logic [NUM_CH*DW-1:0]   DATA_i,
  output logic                   CTS,
  output logic                   pending,
  output logic                   period_tick,
  output logic [NUM_CH-1:0]      pwm_o
);
  // Last count of a period: 2**DW-2, so a full-scale duty of 2**DW-1 stays high throughout.
  localparam logic [DW-1:0] CNT_LAST = {{(DW-1){1'b1}}, 1'b0};

  logic [PRESCALE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [DW-1:0]                cnt_q, cnt_d;
  logic [NUM_CH-1:0][DW-1:0]    frame_in;
  logic [NUM_CH-1:0][DW-1:0]    shadow_q, shadow_d;
  logic [NUM_CH-1:0][DW-1:0]    active_q, active_d;
  logic                         pending_q, pending_d;
  logic                         cts_q, pt_q;
  logic                         tick, boundary, commit;

  assign frame_in = DATA_i;

  always_comb begin
    // >= rather than == so a prescale lowered below pre_cnt fires at once instead of wrapping.
    tick     = enable && (pre_cnt_q >= prescale);
    boundary = tick && (cnt_q == CNT_LAST);
    // While idle there is no period to protect, so frames commit immediately.
    commit   = (boundary || !enable) && (pending_q || load);

    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    if (!enable || tick) pre_cnt_d = '0;

    cnt_d = cnt_q;
    if (!enable || boundary) cnt_d = '0;
    else if (tick)           cnt_d = cnt_q + DW'(1);

    shadow_d = load ? frame_in : shadow_q;

    active_d = active_q;
    if (commit) active_d = load ? frame_in : shadow_q;

    pending_d = pending_q;
    if (commit)    pending_d = 1'b0;
    else if (load) pending_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      cts_q     <= 1'b0;
      pt_q      <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cts_q     <= commit;
      pt_q      <= boundary;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    pwm_lane #(.DW(DW)) u_lane (
      .sys_clk    (sys_clk),
      .sys_resetb (sys_resetb),
      .en_i       (enable),
      .cnt_i      (cnt_q),
      .duty_i     (active_q[k]),
      .pwm_o      (pwm_o[k])
    );
  end

  assign CTS         = cts_q;
  assign pending     = pending_q;
  assign period_tick = pt_q;
endmodule

// File: tb/tb_pwm_frame_driver.sv
// Scenario bench for pwm_frame_driver: directed period/commit checks plus a random run
// compared cycle by cycle against a behavioural model of the duty/commit rules.

module tb_pwm_frame_driver;
  logic        sys_clk = 1'b0;
  logic        sys_resetb = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic        load = 1'b0;
  logic [95:0] DATA_i = '0;
  logic        CTS, pending, period_tick;
  logic [11:0] pwm_o;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  pwm_frame_driver dut (
    .sys_clk     (sys_clk),
    .sys_resetb  (sys_resetb),
    .enable      (enable),
    .prescale    (prescale),
    .load        (load),
    .DATA_i      (DATA_i),
    .CTS         (CTS),
    .pending     (pending),
    .period_tick (period_tick),
    .pwm_o       (pwm_o)
  );

  // Reference model: per-channel duty arrays, a tick count modulo 255 and a commit flag.
  int         m_pre, m_cnt;
  logic [7:0] m_sh [12];
  logic [7:0] m_act[12];
  logic       m_pend, m_cts, m_pt;
  logic [11:0] m_pwm;
  wire m_tick   = enable && (m_pre >= int'(prescale));
  wire m_wrap   = m_tick && (m_cnt == 254);
  wire m_commit = (m_wrap || !enable) && (m_pend || load);

  always @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      m_pre <= 0; m_cnt <= 0; m_pend <= 0; m_cts <= 0; m_pt <= 0; m_pwm <= '0;
      for (int k = 0; k < 12; k++) begin m_sh[k] <= 0; m_act[k] <= 0; end
    end else begin
      m_pre <= (!enable || m_tick) ? 0 : (m_pre + 1) % 256;
      m_cnt <= !enable ? 0 : (m_tick ? (m_cnt + 1) % 255 : m_cnt);
      for (int k = 0; k < 12; k++) begin
        m_pwm[k] <= enable && (m_cnt < int'(m_act[k]));
        if (load) m_sh[k] <= DATA_i[k*8 +: 8];
        if (m_commit) m_act[k] <= load ? DATA_i[k*8 +: 8] : m_sh[k];
      end
      m_pend <= m_commit ? 1'b0 : (load ? 1'b1 : m_pend);
      m_cts  <= m_commit;
      m_pt   <= m_wrap;
    end
  end

  wire [14:0] dut_v = {CTS, pending, period_tick, pwm_o};
  wire [14:0] mdl_v = {m_cts, m_pend, m_pt, m_pwm};

  function automatic logic [95:0] rand_frame();
    logic [95:0] f;
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0:       f[k*8 +: 8] = 8'h00;
        1:       f[k*8 +: 8] = 8'hFF;
        default: f[k*8 +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return f;
  endfunction

  task automatic wait_cts(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge sys_clk);
      if (CTS) seen = 1;
    end
  endtask

  task automatic pulse_load(input logic [95:0] f);
    DATA_i = f; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    int ncts, bad;
    enable = 1'b1; load = 1'b1; prescale = 8'd0; DATA_i = rand_frame();
    #1 sys_resetb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_v !== 15'd0) begin errors++; $display("FAIL reset_hold: got %h expected 0", dut_v); end
    end
    sys_resetb = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    ncts = 0; bad = 0;
    for (int i = 0; i < 270; i++) begin
      @(negedge sys_clk);
      ncts += int'(CTS);
      if (dut_v !== mdl_v) bad++;
    end
    checks++;
    if (ncts != 1) begin errors++; $display("FAIL reset_first_cts: got %0d expected 1", ncts); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_model: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_half_duty();
    logic [95:0] f;
    bit seen;
    int n_hi, n_oth, n_pt, bad;
    f = '0; f[7:0] = 8'h80;
    pulse_load(f);
    wait_cts(600, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL half_commit: got no CTS expected CTS"); end
    repeat (2) @(negedge sys_clk);
    n_hi = 0; n_oth = 0; n_pt = 0; bad = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      n_hi  += int'(pwm_o[0]);
      n_oth += int'(pwm_o[11:1] != 0);
      n_pt  += int'(period_tick);
      if (dut_v !== mdl_v) bad++;
    end
    checks++; if (n_hi != 128) begin errors++; $display("FAIL half_high: got %0d expected 128", n_hi); end
    checks++; if (n_oth != 0) begin errors++; $display("FAIL half_others: got %0d expected 0", n_oth); end
    checks++; if (n_pt != 1) begin errors++; $display("FAIL half_period_tick: got %0d expected 1", n_pt); end
    checks++; if (bad != 0) begin errors++; $display("FAIL half_model: got %0d expected 0", bad); end
  endtask

  task automatic test_extremes();
    logic [95:0] f;
    bit seen;
    int hi5, lo6;
    f = rand_frame(); f[47:40] = 8'h00; f[55:48] = 8'hFF;
    pulse_load(f);
    wait_cts(600, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL extreme_commit: got no CTS expected CTS"); end
    repeat (2) @(negedge sys_clk);
    hi5 = 0; lo6 = 0;
    for (int i = 0; i < 765; i++) begin
      @(negedge sys_clk);
      hi5 += int'(pwm_o[5]);
      lo6 += int'(!pwm_o[6]);
    end
    checks++; if (hi5 != 0) begin errors++; $display("FAIL duty00_high: got %0d expected 0", hi5); end
    checks++; if (lo6 != 0) begin errors++; $display("FAIL dutyFF_low: got %0d expected 0", lo6); end
  endtask

  task automatic test_overwrite();
    logic [95:0] f;
    int ncts, n_hi, bad;
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin @(negedge sys_clk); seen = period_tick; end
    f = '0; f[7:0] = 8'h10; pulse_load(f);
    repeat (19) @(negedge sys_clk);
    f[7:0] = 8'h20; pulse_load(f);
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL overwrite_pending: got %b expected 1", pending); end
    ncts = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      ncts += int'(CTS);
      if (dut_v !== mdl_v) bad++;
    end
    n_hi = 0;
    for (int i = 0; i < 255; i++) begin @(negedge sys_clk); n_hi += int'(pwm_o[0]); end
    checks++; if (ncts != 1) begin errors++; $display("FAIL overwrite_cts: got %0d expected 1", ncts); end
    checks++; if (n_hi != 32) begin errors++; $display("FAIL overwrite_duty: got %0d expected 32", n_hi); end
    checks++; if (bad != 0) begin errors++; $display("FAIL overwrite_model: got %0d expected 0", bad); end
  endtask

  task automatic test_load_at_boundary();
    logic [95:0] f;
    int d, ncts, n_hi;
    bit found;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_cnt == 254 && m_pre >= int'(prescale)) found = 1;
      else @(negedge sys_clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL boundary_reach: got timeout expected cnt 254"); end
    d = $urandom_range(1, 254);
    f = rand_frame(); f[7:0] = 8'(d);
    pulse_load(f);
    checks++;
    if ({CTS, pending, period_tick} !== 3'b101) begin
      errors++; $display("FAIL boundary_flags: got %b expected 101", {CTS, pending, period_tick});
    end
    ncts = 0; n_hi = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge sys_clk);
      ncts += int'(CTS);
      n_hi += int'(pwm_o[0]);
    end
    checks++; if (ncts != 0) begin errors++; $display("FAIL boundary_extra_cts: got %0d expected 0", ncts); end
    checks++; if (n_hi != d) begin errors++; $display("FAIL boundary_duty: got %0d expected %0d", n_hi, d); end
  endtask

  task automatic test_prescale_change();
    int gap, bad;
    bit found;
    prescale = 8'd3;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge sys_clk);
      if (m_cnt == 253 && m_pre == 2) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL prescale_reach: got timeout expected pre_cnt 2"); end
    prescale = 8'd1;
    gap = 0; bad = 0;
    for (int i = 1; i <= 600 && gap == 0; i++) begin
      @(negedge sys_clk);
      if (dut_v !== mdl_v) bad++;
      if (period_tick) gap = i;
    end
    checks++; if (gap != 3) begin errors++; $display("FAIL prescale_first_wrap: got %0d expected 3", gap); end
    gap = 0;
    for (int i = 1; i <= 1200 && gap == 0; i++) begin
      @(negedge sys_clk);
      if (dut_v !== mdl_v) bad++;
      if (period_tick) gap = i;
    end
    checks++; if (gap != 510) begin errors++; $display("FAIL prescale_period: got %0d expected 510", gap); end
    checks++; if (bad != 0) begin errors++; $display("FAIL prescale_model: got %0d expected 0", bad); end
    prescale = 8'd0;
  endtask

  task automatic test_disable_commit();
    logic [95:0] f;
    logic [11:0] exp_first;
    int d, bad, n_hi;
    while (m_cnt > 240 || pending) @(negedge sys_clk);
    d = $urandom_range(1, 254);
    f = rand_frame(); f[7:0] = 8'(d);
    for (int k = 0; k < 12; k++) exp_first[k] = (f[k*8 +: 8] != 8'h00);
    DATA_i = f; load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0; enable = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({CTS, pending} !== 2'b10) begin errors++; $display("FAIL disable_cts: got %b expected 10", {CTS, pending}); end
    checks++;
    if (pwm_o !== 12'd0) begin errors++; $display("FAIL disable_pwm: got %h expected 0", pwm_o); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if ({CTS, period_tick, pwm_o} !== 14'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL disable_idle: got %0d expected 0", bad); end
    enable = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (pwm_o !== exp_first) begin errors++; $display("FAIL reenable_first: got %h expected %h", pwm_o, exp_first); end
    n_hi = int'(pwm_o[0]);
    for (int i = 1; i < 255; i++) begin @(negedge sys_clk); n_hi += int'(pwm_o[0]); end
    checks++; if (n_hi != d) begin errors++; $display("FAIL reenable_duty: got %0d expected %0d", n_hi, d); end
  endtask

  task automatic test_reset_midperiod();
    pulse_load(rand_frame());
    repeat ($urandom_range(3, 60)) @(negedge sys_clk);
    #2 sys_resetb = 1'b0;
    #1;
    checks++;
    if (dut_v !== 15'd0) begin errors++; $display("FAIL reset_async: got %h expected 0", dut_v); end
    @(negedge sys_clk);
    sys_resetb = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({CTS, pending, pwm_o} !== 14'd0) begin
      errors++; $display("FAIL reset_discard: got %h expected 0", {CTS, pending, pwm_o});
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (dut_v !== mdl_v) begin
        bad++;
        if (bad <= 3) $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_v, mdl_v);
      end
      load   = ($urandom_range(0, 59) == 0);
      DATA_i = rand_frame();
      if ($urandom_range(0, 499) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) prescale = 8'($urandom_range(0, 3));
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_model: got %0d bad cycles expected 0", bad); end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_half_duty();
    test_extremes();
    test_overwrite();
    test_load_at_boundary();
    test_prescale_change();
    test_disable_commit();
    test_reset_midperiod();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
